// File: rtl/fft_sdf_stream.sv
// Streaming radix-2 SDF FFT, decimation in frequency, LOG2N stages.
// Define FFT_STAGE_SCALE_EN to halve every stage result (1/N gain).
module fft_sdf_stream #(
    parameter int DATA_W      = 12,
    parameter int LOG2N       = 3,
    parameter int TW_W        = 10,
    parameter int INPUT_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x_r,
    input  logic [DATA_W-1:0] x_i,
    output logic              out_valid,
    output logic [DATA_W-1:0] X_r,
    output logic [DATA_W-1:0] X_i,
    output logic [LOG2N-1:0]  out_idx,
    output logic              out_sof
);

    localparam int N   = 1 << LOG2N;
    localparam int L   = N + LOG2N - 2;
    localparam int FW  = $clog2(L + 1);
    localparam int PW  = DATA_W + TW_W + 1;
    localparam int TSH = 22 - TW_W;
    localparam logic [FW-1:0] LF = FW'(L);
    localparam logic signed [PW-1:0] RND = PW'(1 << (TW_W - 3));

    // Twiddle W_N^k from a 16-point table held at 2^20 scale.
    function automatic logic signed [TW_W-1:0] tw_val(
        input int   k,
        input logic im
    );
        longint v;
        longint t;
        int     m;
        m = k << (4 - LOG2N);
        v = 64'sd0;
        if (!im) begin
            case (m)
                0:       v = 64'sd1048576;
                1:       v = 64'sd968758;
                2:       v = 64'sd741455;
                3:       v = 64'sd401273;
                5:       v = -64'sd401273;
                6:       v = -64'sd741455;
                7:       v = -64'sd968758;
                default: v = 64'sd0;
            endcase
        end else begin
            case (m)
                1:       v = -64'sd401273;
                2:       v = -64'sd741455;
                3:       v = -64'sd968758;
                4:       v = -64'sd1048576;
                5:       v = -64'sd968758;
                6:       v = -64'sd741455;
                7:       v = -64'sd401273;
                default: v = 64'sd0;
            endcase
        end
        t = (v + (64'sd1 <<< (TSH - 1))) >>> TSH;
        return t[TW_W-1:0];
    endfunction

    // Clamp a wide signed value into the DATA_W signed range.
    function automatic logic [DATA_W-1:0] sat_w(input logic [PW-1:0] v);
        if (!v[PW-1] && (|v[PW-2:DATA_W-1]))
            return {1'b0, {(DATA_W-1){1'b1}}};
        else if (v[PW-1] && !(&v[PW-2:DATA_W-1]))
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    logic [FW-1:0]    fill_q, fill_d;
    logic [LOG2N-1:0] ocnt_q, ocnt_d;
    logic [LOG2N-1:0] idx_q, idx_d;
    logic             ov_q, ov_d;
    logic             sof_q, sof_d;

    logic [LOG2N:0][DATA_W-1:0] st_r;
    logic [LOG2N:0][DATA_W-1:0] st_i;

    logic signed [DATA_W-1:0] xs_r, xs_i;

    assign xs_r    = $signed(x_r) >>> INPUT_SHIFT;
    assign xs_i    = $signed(x_i) >>> INPUT_SHIFT;
    assign st_r[0] = xs_r;
    assign st_i[0] = xs_i;

    for (genvar s = 0; s < LOG2N; s++) begin : g_st
        localparam int D  = N >> (s + 1);
        localparam int CW = LOG2N - s;
        localparam logic [FW-1:0] OS = FW'(N - (N >> s) + s);

        logic [CW-1:0]     cnt_q, cnt_d;
        logic [DATA_W-1:0] dlr_q [D];
        logic [DATA_W-1:0] dli_q [D];
        logic [DATA_W-1:0] or_q, oi_q;
        logic [DATA_W-1:0] outr, outi, pushr, pushi;
        logic signed [DATA_W-1:0] ar, ai, br, bi;
        logic signed [DATA_W:0]   sr, si, dr, di;
        logic signed [TW_W-1:0]   wr, wi;
        logic signed [PW-1:0]     sxr, sxi, dxr, dxi;
        logic signed [PW-1:0]     wxr, wxi, pr, pi, pqr, pqi;
        logic adv, bfly, use_w;

        // Data for this stage starts OS accepts after reset.
        if (s == 0) begin : g_a0
            assign adv = in_valid;
        end else begin : g_an
            assign adv = in_valid & (fill_q >= OS);
        end

        if (D > 1) begin : g_tw
            logic [CW-2:0]          k;
            logic signed [TW_W-1:0] rom_r [D];
            logic signed [TW_W-1:0] rom_i [D];
            for (genvar j = 0; j < D; j++) begin : g_rom
                localparam logic signed [TW_W-1:0] WR = tw_val(j << s, 1'b0);
                localparam logic signed [TW_W-1:0] WI = tw_val(j << s, 1'b1);
                assign rom_r[j] = WR;
                assign rom_i[j] = WI;
            end
            assign k     = cnt_q[CW-2:0];
            assign wr    = rom_r[k];
            assign wi    = rom_i[k];
            assign use_w = (k != '0);
        end else begin : g_notw
            assign wr    = '0;
            assign wi    = '0;
            assign use_w = 1'b0;
        end

        assign ar    = dlr_q[D-1];
        assign ai    = dli_q[D-1];
        assign br    = st_r[s];
        assign bi    = st_i[s];
        assign bfly  = cnt_q[CW-1];
        assign cnt_d = cnt_q + CW'(1);

        // Butterfly, twiddle product and fill/butterfly phase select.
        always_comb begin
            sr = {ar[DATA_W-1], ar} + {br[DATA_W-1], br};
            si = {ai[DATA_W-1], ai} + {bi[DATA_W-1], bi};
            dr = {ar[DATA_W-1], ar} - {br[DATA_W-1], br};
            di = {ai[DATA_W-1], ai} - {bi[DATA_W-1], bi};
`ifdef FFT_STAGE_SCALE_EN
            sr = sr >>> 1;
            si = si >>> 1;
            dr = dr >>> 1;
            di = di >>> 1;
`endif
            sxr = {{(PW-DATA_W-1){sr[DATA_W]}}, sr};
            sxi = {{(PW-DATA_W-1){si[DATA_W]}}, si};
            dxr = {{(PW-DATA_W-1){dr[DATA_W]}}, dr};
            dxi = {{(PW-DATA_W-1){di[DATA_W]}}, di};
            wxr = {{(PW-TW_W){wr[TW_W-1]}}, wr};
            wxi = {{(PW-TW_W){wi[TW_W-1]}}, wi};
            pr  = dxr * wxr - dxi * wxi;
            pi  = dxr * wxi + dxi * wxr;
            pqr = (pr + RND) >>> (TW_W - 2);
            pqi = (pi + RND) >>> (TW_W - 2);
            outr  = ar;
            outi  = ai;
            pushr = br;
            pushi = bi;
            if (bfly) begin
                outr = sat_w(sxr);
                outi = sat_w(sxi);
                if (use_w) begin
                    pushr = sat_w(pqr);
                    pushi = sat_w(pqi);
                end else begin
                    pushr = sat_w(dxr);
                    pushi = sat_w(dxi);
                end
            end
        end

        // Delay line, phase counter and stage output register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
                or_q  <= '0;
                oi_q  <= '0;
                for (int q = 0; q < D; q++) begin
                    dlr_q[q] <= '0;
                    dli_q[q] <= '0;
                end
            end else begin
                if (adv) begin
                    cnt_q    <= cnt_d;
                    dlr_q[0] <= pushr;
                    dli_q[0] <= pushi;
                    for (int q = 1; q < D; q++) begin
                        dlr_q[q] <= dlr_q[q-1];
                        dli_q[q] <= dli_q[q-1];
                    end
                end
                if (in_valid) begin
                    or_q <= outr;
                    oi_q <= outi;
                end
            end
        end

        assign st_r[s+1] = or_q;
        assign st_i[s+1] = oi_q;
    end

    // Fill count, output valid, bin counter and frame start.
    always_comb begin
        fill_d = fill_q;
        if (in_valid && (fill_q != LF)) fill_d = fill_q + FW'(1);
        ov_d   = in_valid && (fill_q == LF);
        ocnt_d = ocnt_q;
        idx_d  = idx_q;
        sof_d  = 1'b0;
        if (ov_d) begin
            ocnt_d = ocnt_q + LOG2N'(1);
            idx_d  = bitrev(ocnt_q);
            sof_d  = (ocnt_q == '0);
        end
    end

    // Output control registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= '0;
            ocnt_q <= '0;
            idx_q  <= '0;
            ov_q   <= 1'b0;
            sof_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            ocnt_q <= ocnt_d;
            idx_q  <= idx_d;
            ov_q   <= ov_d;
            sof_q  <= sof_d;
        end
    end

    assign out_valid = ov_q;
    assign out_sof   = sof_q;
    assign out_idx   = idx_q;
    assign X_r       = st_r[LOG2N];
    assign X_i       = st_i[LOG2N];

endmodule

// File: doc/fft_sdf_stream.md
# fft_sdf_stream

Parametrised streaming radix-2 single-path delay-feedback (SDF) FFT, decimation in frequency, with LOG2N chained butterfly stages. It replaces the fixed 8-point three-stage chain with one block whose point count and width are parameters. It adds the following:
- a valid-gated stall capability,
- per-bin index and frame-start outputs,
- saturating arithmetic,
- an optional per-stage scaling mode.

It sits between the sample source and the spectral post-processing logic.

## Interface
- DATA_W, 12: I/O sample width, signed two's complement, per real/imag component.
- LOG2N, 3: log2 of the point count. Legal values are 2, 3, 4 (N = 4, 8, 16).
- TW_W, 10: twiddle width, signed Q1.(TW_W-2).
- INPUT_SHIFT, 2: arithmetic right shift applied to x_r/x_i before stage 0.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  sample accept strobe. The whole pipeline advances only on cycles where this is 1.
- x_r, x_i  input  DATA_W  input sample, real and imaginary.
- out_valid  output  1  X_r/X_i/out_idx carry a new bin this cycle.
- X_r, X_i  output  DATA_W  output bin, real and imaginary.
- out_idx  output  LOG2N  bin index of the current output, in bit-reversed order.
- out_sof  output  1  high with out_valid on bin 0 of each frame.

## Operation
- Input alignment:
  - Frame boundaries are implicit: the first accepted sample after reset is sample 0 of frame 0.
  - Every group of N accepted samples forms one frame.
- Stage s (0..LOG2N-1):
  - Has delay line depth D = N>>(s+1) and a mod-2D counter that advances on accept.
  - Counter < D (fill phase): the incoming sample is pushed into the delay line. The stage outputs the popped delay-line word, which is the previous twiddled difference.
  - Counter >= D (butterfly phase), with a = popped, b = incoming:
    - Stage outputs a+b.
    - The delay line is pushed with (a-b)·W, where W = W_N^((cnt-D)·2^s).
- Twiddle ROM:
  - Constant cos/-sin table of N/2 entries, each round(2^(TW_W-2)·value).
  - Index 0 (W = 1) bypasses the multiplier.
- Arithmetic:
  - Sum and difference are computed at DATA_W+1 bits.
  - Complex product is computed at full width, rounded half-up, then shifted right by TW_W-2.
  - Every stage result saturates to the DATA_W signed range: max 2^(DATA_W-1)-1, min -2^(DATA_W-1).
- Each stage output is registered, with the register enabled by in_valid.
- Output order is bit-reversed.
  - out_idx = bitrev(output counter). This counter is mod N and advances on each out_valid.
  - out_sof = out_valid & (output counter == 0).
- Fill counter:
  - Counts accepts since reset and saturates at L = N+LOG2N-2.
  - out_valid is registered and set to in_valid & (fill count == L), where the comparison uses the count before this accept.

## Timing
- Reset values:
  - out_valid = 0, out_sof = 0, X_r = X_i = 0, out_idx = 0.
  - All delay lines, stage counters, the fill counter and the output counter are cleared to 0.
- Reset mid-frame behaves as a full restart: the partial frame is discarded and the next accept is sample 0 of a new frame.
- Latency is counted in accepts, not in cycles.
  - Bin 0 of frame f is presented the cycle after the accept of overall sample N·f + L.
  - For N = 8 this is sample 9.
  - With continuous in_valid, out_valid rises 10 cycles after the first accept (N = 8) and then stays high.
- Stall behaviour:
  - in_valid = 0 freezes all state; X_r/X_i/out_idx hold their values and out_valid = 0.
  - Stall duration has no effect on results.
- There is no backpressure. The consumer must take every out_valid cycle.

## Configuration
- Macro FFT_STAGE_SCALE_EN.
- Defined:
  - Each stage sum/difference is arithmetic-shifted right 1 before saturation.
  - Total gain is 1/N, and overflow is impossible for any input after INPUT_SHIFT.
- Undefined:
  - No per-stage shift; gain is N.
  - Stage saturation is the only overflow protection.

## Test plan
All scenarios use N = 8, DATA_W = 12, TW_W = 10, INPUT_SHIFT = 2, macro undefined unless stated. "Frame" means the second frame output, i.e. the first frame that follows the one-frame priming.

- Impulse: x_r = 400 at sample 0, all else 0 (then repeated zero frames).
  - Required: all 8 bins X_r = 100, X_i = 0.
  - out_idx sequence is 0,4,2,6,1,5,3,7.
  - out_sof is high on the first bin only.
- DC with scaling:
  - Macro undefined: x_r = 400 on all samples → bin 0 X_r = 800, all other bins 0 (±1 LSB allowed on twiddled bins).
  - Macro defined: the same input gives bin 0 = 100.
- Nyquist: x_r alternating +400/-400.
  - Required: out_idx 4 gives X_r = 800; all other bins 0.
- Stall invariance: repeat the impulse and DC tests with in_valid toggling 1,0,1,0 and with random gaps.
  - Required: the out_valid-qualified output stream is identical to the continuous case, and outputs hold during gaps.
- Saturation: x_r = 2047 on all samples, macro undefined.
  - Required: stage values 1022 → 2044 → 2047 (saturated), so bin 0 = 2047.
  - No wrap to negative on any bin.
- Reset mid-frame: assert rst_n = 0 for 1 cycle after sample 5.
  - Required: out_valid = 0 and X = 0 the cycle after reset.
  - The next impulse frame yields the correct all-100 spectrum, with latency re-counted from the post-reset sample 0.
